// File: rtl/maze_scenario_player.sv
// maze_scenario_player: table-driven stimulus sequencer for the maze runner.
// Plays up to NUM_STEPS programmed steps. Each step drives line_theta,
// line_present and the bump switches for a hold count. An optional
// per-step check compares theta_robot against the step theta.
// Optional feature: define SCN_LOOP_EN to add the loop input and the
// loop_cnt output, which allow continuous replay of the table.
module maze_scenario_player #(
  parameter  int NUM_STEPS = 16,
  parameter  int THETA_W   = 13,
  parameter  int HOLD_W    = 24,
  parameter  int TOL       = 16,
  localparam int IW        = $clog2(NUM_STEPS),
  localparam int DW        = THETA_W + 4 + HOLD_W
) (
  input  logic               clk,
  input  logic               RST_n,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic [IW:0]        num_steps,
  input  logic               start,
  input  logic               abort,
  input  logic [THETA_W-1:0] theta_robot,
`ifdef SCN_LOOP_EN
  input  logic               loop,
  output logic [7:0]         loop_cnt,
`endif
  output logic [THETA_W-1:0] line_theta,
  output logic               line_present,
  output logic               BMPL_n,
  output logic               BMPR_n,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [IW-1:0]      err_step,
  output logic [IW-1:0]      step_idx
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_CHECK, S_DONE} state_e;

  localparam logic [IW:0]      NS_V  = (IW+1)'(NUM_STEPS);
  localparam logic [THETA_W:0] TOL_V = (THETA_W+1)'(TOL);

  state_e               state_q;
  logic [DW-1:0]        tbl [NUM_STEPS];
  logic [THETA_W-1:0]   line_theta_q;
  logic                 line_present_q, bmpl_n_q, bmpr_n_q;
  logic                 busy_q, done_q, pass_q, chk_q;
  logic [IW-1:0]        err_step_q, step_idx_q;
  logic [HOLD_W-1:0]    cnt_q;
`ifdef SCN_LOOP_EN
  logic [7:0]           loop_cnt_q;
`endif

  // Current table entry, MSB first: {theta, present, bmpl, bmpr, check, hold}
  logic [DW-1:0]        ent;
  logic [THETA_W-1:0]   e_theta;
  logic                 e_pres, e_bl, e_br, e_chk;
  logic [HOLD_W-1:0]    e_hold;

  assign ent     = tbl[step_idx_q];
  assign e_theta = ent[DW-1 -: THETA_W];
  assign e_pres  = ent[HOLD_W+3];
  assign e_bl    = ent[HOLD_W+2];
  assign e_br    = ent[HOLD_W+1];
  assign e_chk   = ent[HOLD_W];
  assign e_hold  = ent[HOLD_W-1:0];

  // One extra bit keeps the difference of two extreme headings from wrapping
  logic signed [THETA_W:0] diff;
  logic [THETA_W:0]        adiff;
  logic                    fail;

  assign diff  = {theta_robot[THETA_W-1], theta_robot}
               - {line_theta_q[THETA_W-1], line_theta_q};
  assign adiff = diff[THETA_W] ? -diff : diff;
  assign fail  = (adiff > TOL_V);

  // Effective step count: 0 and oversize requests both mean a full table
  logic [IW:0] n_eff;
  logic        last, step_end;

  assign n_eff    = (num_steps == '0 || num_steps > NS_V) ? NS_V : num_steps;
  assign last     = ({1'b0, step_idx_q} == n_eff - (IW+1)'(1));
  assign step_end = (state_q == S_HOLD && cnt_q == HOLD_W'(1) && !chk_q)
                 || (state_q == S_CHECK);

  // Step table: writable only while idle so a run sees a frozen program
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) tbl[wr_addr] <= wr_data;
  end

  // Playback sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!RST_n) begin
      state_q        <= S_IDLE;
      line_theta_q   <= '0;
      line_present_q <= 1'b1;
      bmpl_n_q       <= 1'b1;
      bmpr_n_q       <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b1;
      chk_q          <= 1'b0;
      err_step_q     <= '0;
      step_idx_q     <= '0;
      cnt_q          <= '0;
`ifdef SCN_LOOP_EN
      loop_cnt_q     <= '0;
`endif
    end else if (abort && busy_q) begin
      // Abort releases line and bumps but keeps theta and the check result
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      line_present_q <= 1'b1;
      bmpl_n_q       <= 1'b1;
      bmpr_n_q       <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            busy_q     <= 1'b1;
            pass_q     <= 1'b1;
            err_step_q <= '0;
            step_idx_q <= '0;
            state_q    <= S_FETCH;
`ifdef SCN_LOOP_EN
            loop_cnt_q <= '0;
`endif
          end
        end
        S_FETCH: begin
          line_theta_q   <= e_theta;
          line_present_q <= e_pres;
          bmpl_n_q       <= ~e_bl;
          bmpr_n_q       <= ~e_br;
          chk_q          <= e_chk;
          cnt_q          <= (e_hold == '0) ? HOLD_W'(1) : e_hold;
          state_q        <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q != HOLD_W'(1)) cnt_q <= cnt_q - HOLD_W'(1);
          else if (chk_q)          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (fail) begin
            pass_q <= 1'b0;
            if (pass_q) err_step_q <= step_idx_q;
          end
        end
        S_DONE: begin
`ifdef SCN_LOOP_EN
          if (loop) begin
            step_idx_q     <= '0;
            line_present_q <= 1'b1;
            bmpl_n_q       <= 1'b1;
            bmpr_n_q       <= 1'b1;
            state_q        <= S_FETCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`endif
        end
        default: state_q <= S_IDLE;
      endcase

      // Step completion; between steps line and bumps go neutral for the
      // FETCH cycle so a one-cycle gap is exactly one cycle wide.
      if (step_end) begin
        if (last) begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
`ifdef SCN_LOOP_EN
          if (loop_cnt_q != 8'hFF) loop_cnt_q <= loop_cnt_q + 8'd1;
`endif
        end else begin
          step_idx_q     <= step_idx_q + IW'(1);
          line_present_q <= 1'b1;
          bmpl_n_q       <= 1'b1;
          bmpr_n_q       <= 1'b1;
          state_q        <= S_FETCH;
        end
      end
    end
  end

  assign line_theta   = line_theta_q;
  assign line_present = line_present_q;
  assign BMPL_n       = bmpl_n_q;
  assign BMPR_n       = bmpr_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_step     = err_step_q;
  assign step_idx     = step_idx_q;
`ifdef SCN_LOOP_EN
  assign loop_cnt     = loop_cnt_q;
`endif

endmodule
